// File: rtl/can_rx_frame_buffer_pkg.sv
// Shared types for the CAN receive frame buffer: the stored frame record,
// the staging FSM states and the data-field length helper.
package can_pkg;

    localparam int MAX_BYTES = 8;

    typedef struct packed {
        logic [28:0] id;
        logic        ext;
        logic        rtr;
        logic [3:0]  dlc;
        logic [63:0] data;
    } can_frame_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        WAIT = 2'd3
    } stage_state_t;

    // Remote frames carry no data; DLC values above the byte limit saturate.
    function automatic logic [3:0] frame_nbytes(input logic       rtr,
                                                input logic [3:0] dlc,
                                                input int         max_bytes);
        logic [3:0] nb;
        nb = dlc;
        if (rtr) begin
            nb = 4'd0;
        end else if (int'(dlc) > max_bytes) begin
            nb = 4'(max_bytes);
        end
        return nb;
    endfunction

endpackage

// File: rtl/can_rx_frame_buffer_fifo.sv
// First-word-fall-through frame FIFO; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module can_frame_fifo
    import can_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  can_frame_t             wr_frame,
    input  logic                   pop,
    output can_frame_t             rd_frame,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    can_frame_t    mem_q [DEPTH];
    can_frame_t    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign count    = count_q;
    assign rd_frame = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);

        if (do_push) begin
            mem_d[wr_ptr_q] = wr_frame;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/can_rx_frame_buffer.sv
// CAN receive frame buffer: stages one frame (header + MSB-first data bits)
// and commits it to the frame FIFO only when the frame ends without error.
module can_rx_frame_buffer
    import can_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int MAX_BYTES = can_pkg::MAX_BYTES
) (
    input  logic                   clk,
    input  logic                   RST,
    input  logic                   bitstrobe,
    input  logic                   rx_bit,
    input  logic                   bitstuff,
    input  logic                   sof,
    input  logic                   dataphase,
    input  logic                   new_id,
    input  logic [28:0]            msg_id,
    input  logic                   ext,
    input  logic                   rtr,
    input  logic [3:0]             pkt_size,
    input  logic                   frame_done,
    input  logic                   frame_err,
    output logic                   enddata,
    input  logic                   rd_en,
    output logic                   rd_valid,
    output logic [28:0]            rd_id,
    output logic                   rd_ext,
    output logic                   rd_rtr,
    output logic [3:0]             rd_dlc,
    output logic [63:0]            rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    input  logic                   ovf_clr
);

    stage_state_t state_q, state_d;
    logic [6:0]   bitcnt_q, bitcnt_d;
    logic [3:0]   nbytes_q, nbytes_d;
    logic [28:0]  id_q, id_d;
    logic         ext_q, ext_d;
    logic         rtr_q, rtr_d;
    logic [3:0]   dlc_q, dlc_d;
    logic [63:0]  data_q, data_d;
    logic         overflow_q, overflow_d;

    logic         commit;
    logic         last_bit;
    logic [6:0]   last_idx;
    logic         fifo_full;
    logic         fifo_empty;
    can_frame_t   wr_frame;
    can_frame_t   head;

    assign last_idx = {nbytes_q, 3'b000} - 7'd1;
    assign last_bit = (bitcnt_q == last_idx);
    assign enddata  = (state_q == DATA) && dataphase && !bitstuff && last_bit;

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        nbytes_d = nbytes_q;
        id_d     = id_q;
        ext_d    = ext_q;
        rtr_d    = rtr_q;
        dlc_d    = dlc_q;
        data_d   = data_q;
        commit   = 1'b0;

        if (bitstrobe) begin
            // sof restarts staging from any state, abandoning a frame in flight
            if (sof) begin
                data_d   = '0;
                bitcnt_d = '0;
                state_d  = HDR;
            end else begin
                case (state_q)
                    HDR: begin
                        if (new_id) begin
                            id_d     = msg_id;
                            ext_d    = ext;
                            rtr_d    = rtr;
                            dlc_d    = pkt_size;
                            nbytes_d = frame_nbytes(rtr, pkt_size, MAX_BYTES);
                            state_d  = (nbytes_d != 4'd0) ? DATA : WAIT;
                        end
                    end
                    DATA: begin
                        if (dataphase && !bitstuff) begin
                            data_d[6'd63 - bitcnt_q[5:0]] = rx_bit;
                            bitcnt_d                      = bitcnt_q + 7'd1;
                            if (last_bit) begin
                                state_d = WAIT;
                            end
                        end
                    end
                    WAIT: begin
                        if (frame_done) begin
                            commit  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end

        // An error on any cycle discards the staged frame, even over a commit
        if (frame_err) begin
            state_d  = IDLE;
            data_d   = '0;
            bitcnt_d = '0;
            commit   = 1'b0;
        end
    end

    always_comb begin
        overflow_d = overflow_q;
        if (ovf_clr) begin
            overflow_d = 1'b0;
        end
        if (commit && fifo_full && !rd_en) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            bitcnt_q   <= '0;
            nbytes_q   <= '0;
            id_q       <= '0;
            ext_q      <= 1'b0;
            rtr_q      <= 1'b0;
            dlc_q      <= '0;
            data_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            nbytes_q   <= nbytes_d;
            id_q       <= id_d;
            ext_q      <= ext_d;
            rtr_q      <= rtr_d;
            dlc_q      <= dlc_d;
            data_q     <= data_d;
            overflow_q <= overflow_d;
        end
    end

    assign wr_frame = '{id: id_q, ext: ext_q, rtr: rtr_q, dlc: dlc_q, data: data_q};

    // Read handshake: the head entry is presented while rd_valid=1; it is
    // consumed at a clock edge where rd_en=1 and rd_valid=1; rd_en alone is ignored.
    can_frame_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (RST),
        .push    (commit),
        .wr_frame(wr_frame),
        .pop     (rd_en),
        .rd_frame(head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

    assign rd_valid = !fifo_empty;
    assign rd_id    = head.id;
    assign rd_ext   = head.ext;
    assign rd_rtr   = head.rtr;
    assign rd_dlc   = head.dlc;
    assign rd_data  = head.data;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_can_rx_frame_buffer.sv
// Directed bench for can_rx_frame_buffer: frames are driven bit by bit, expected
// FIFO entries are queued at stimulus time and checked by a draining monitor.
module tb_can_rx_frame_buffer;

    localparam int DEPTH = 4;
    localparam int FW    = 99;

    logic                   clk;
    logic                   RST;
    logic                   bitstrobe, rx_bit, bitstuff, sof, dataphase, new_id;
    logic [28:0]            msg_id;
    logic                   ext, rtr;
    logic [3:0]             pkt_size;
    logic                   frame_done, frame_err;
    logic                   enddata;
    logic                   rd_en, rd_valid;
    logic [28:0]            rd_id;
    logic                   rd_ext, rd_rtr;
    logic [3:0]             rd_dlc;
    logic [63:0]            rd_data;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow, ovf_clr;

    logic                   drain_en, drain_rd, stim_rd;
    logic [FW-1:0]          exp_q[$];
    int                     n_cmp = 0;
    int                     n_bad = 0;
    int                     ed_cnt, ed_pos;

    assign rd_en = drain_rd | stim_rd;

    can_rx_frame_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .RST(RST), .bitstrobe(bitstrobe), .rx_bit(rx_bit), .bitstuff(bitstuff),
        .sof(sof), .dataphase(dataphase), .new_id(new_id), .msg_id(msg_id), .ext(ext),
        .rtr(rtr), .pkt_size(pkt_size), .frame_done(frame_done), .frame_err(frame_err),
        .enddata(enddata), .rd_en(rd_en), .rd_valid(rd_valid), .rd_id(rd_id),
        .rd_ext(rd_ext), .rd_rtr(rd_rtr), .rd_dlc(rd_dlc), .rd_data(rd_data),
        .count(count), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drains the FIFO while enabled; pops land on the next rising edge
    initial begin
        drain_rd = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            drain_rd = drain_en && rd_valid && !RST;
        end
    end

    // Scoreboard monitor: every accepted pop is compared with the queue head
    initial begin
        forever begin
            @(negedge clk);
            if (rd_en && rd_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL frame: got %h expected nothing", {rd_id, rd_ext, rd_rtr, rd_dlc, rd_data});
                end else begin
                    check("frame", {rd_id, rd_ext, rd_rtr, rd_dlc, rd_data}, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; applies one bitstrobe cycle followed by one idle cycle.
    task automatic strobe(input logic s, input logic nid, input logic dp, input logic st,
                          input logic b, input logic done, input logic pop, output logic ed);
        sof = s; new_id = nid; dataphase = dp; bitstuff = st; rx_bit = b;
        frame_done = done; stim_rd = pop; bitstrobe = 1'b1;
        #1;
        ed = enddata;
        @(posedge clk);
        #1;
        bitstrobe = 1'b0; sof = 1'b0; new_id = 1'b0; frame_done = 1'b0;
        bitstuff = 1'b0; stim_rd = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [28:0] id, input logic e, input logic r,
                              input logic [3:0] dlc, input logic [63:0] data,
                              input int stuff_every, input int err_at,
                              input logic exp_commit, input logic pop_at_done,
                              output int o_cnt, output int o_pos);
        int         nb;
        logic       ed;
        logic [63:0] mask;
        nb    = r ? 0 : ((int'(dlc) > 8) ? 8 : int'(dlc));
        mask  = (nb == 0) ? 64'h0 : ~(64'hFFFF_FFFF_FFFF_FFFF >> (8 * nb));
        o_cnt = 0;
        o_pos = 0;
        msg_id = id; ext = e; rtr = r; pkt_size = dlc;
        strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ed); o_cnt += int'(ed);
        for (int i = 0; i < 3; i++) begin
            strobe(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ed); o_cnt += int'(ed);
        end
        strobe(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ed); o_cnt += int'(ed);
        for (int i = 0; i < 8 * nb; i++) begin
            if (stuff_every > 0 && i > 0 && (i % stuff_every) == 0) begin
                strobe(1'b0, 1'b0, 1'b1, 1'b1, ~data[63-i], 1'b0, 1'b0, ed); o_cnt += int'(ed);
            end
            strobe(1'b0, 1'b0, 1'b1, 1'b0, data[63-i], 1'b0, 1'b0, ed);
            if (ed) begin
                o_cnt++;
                o_pos = i + 1;
            end
            if (i == err_at) begin
                frame_err = 1'b1;
                @(posedge clk);
                #1;
                frame_err = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            strobe(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ed); o_cnt += int'(ed);
        end
        if (exp_commit) exp_q.push_back({id, e, r, dlc, data & mask});
        strobe(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, pop_at_done, ed); o_cnt += int'(ed);
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rd_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, FW'(exp_q.size() == 0 && !rd_valid), FW'(1));
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RST = 1'b1;
        bitstrobe = 0; rx_bit = 0; bitstuff = 0; sof = 0; dataphase = 0; new_id = 0;
        msg_id = '0; ext = 0; rtr = 0; pkt_size = '0; frame_done = 0; frame_err = 0;
        ovf_clr = 0; stim_rd = 0; drain_en = 1'b0;

        @(negedge clk);
        check("reset rd_valid", FW'(rd_valid), FW'(0));
        check("reset count", FW'(count), FW'(0));
        check("reset overflow", FW'(overflow), FW'(0));
        check("reset enddata", FW'(enddata), FW'(0));
        check("reset head", {rd_id, rd_ext, rd_rtr, rd_dlc, rd_data}, FW'(0));
        repeat (2) @(posedge clk);
        #1;
        RST = 1'b0;
        @(posedge clk);
        #1;

        drain_en = 1'b1;
        // standard frame, ID 0x123, 2 bytes
        send_frame(29'h123, 1'b0, 1'b0, 4'd2, 64'hA53C_0000_0000_0000, 0, -1, 1'b1, 1'b0, ed_cnt, ed_pos);
        check("std enddata count", FW'(ed_cnt), FW'(1));
        check("std enddata bit", FW'(ed_pos), FW'(16));
        // stuff bits inside the data field, one right before the last bit
        send_frame(29'h456, 1'b0, 1'b0, 4'd2, 64'hA53C_0000_0000_0000, 5, -1, 1'b1, 1'b0, ed_cnt, ed_pos);
        check("stuff enddata count", FW'(ed_cnt), FW'(1));
        check("stuff enddata bit", FW'(ed_pos), FW'(16));
        // remote frame with DLC 5: no data field
        send_frame(29'h7FF, 1'b0, 1'b1, 4'd5, 64'hDEAD_BEEF_0000_0000, 0, -1, 1'b1, 1'b0, ed_cnt, ed_pos);
        check("rtr enddata count", FW'(ed_cnt), FW'(0));
        // DLC 12 saturates to 8 bytes, extended ID
        send_frame(29'h1ABC_DE12, 1'b1, 1'b0, 4'd12, 64'h0123_4567_89AB_CDEF, 0, -1, 1'b1, 1'b0, ed_cnt, ed_pos);
        check("dlc12 enddata count", FW'(ed_cnt), FW'(1));
        check("dlc12 enddata bit", FW'(ed_pos), FW'(64));
        wait_empty("drain after basic frames");

        // error in the data field, then a good frame
        drain_en = 1'b0;
        send_frame(29'h0AA, 1'b0, 1'b0, 4'd2, 64'hFFFF_0000_0000_0000, 0, 5, 1'b0, 1'b0, ed_cnt, ed_pos);
        check("err enddata count", FW'(ed_cnt), FW'(0));
        check("err count", FW'(count), FW'(0));
        send_frame(29'h0BB, 1'b0, 1'b0, 4'd1, 64'h5A00_0000_0000_0000, 0, -1, 1'b1, 1'b0, ed_cnt, ed_pos);
        check("after err count", FW'(count), FW'(1));
        drain_en = 1'b1;
        wait_empty("drain after err");
        drain_en = 1'b0;

        // DEPTH+1 frames without reads: last one dropped
        for (int k = 0; k < DEPTH + 1; k++) begin
            send_frame(29'(32'h100 + k), 1'b0, 1'b0, 4'd1, {8'(8'h10 + k), 56'h0}, 0, -1,
                       (k < DEPTH), 1'b0, ed_cnt, ed_pos);
        end
        check("full count", FW'(count), FW'(DEPTH));
        check("full overflow", FW'(overflow), FW'(1));
        check("full rd_valid", FW'(rd_valid), FW'(1));
        // pop and push in the same cycle while full
        send_frame(29'h1F0, 1'b0, 1'b0, 4'd1, 64'hC300_0000_0000_0000, 0, -1, 1'b1, 1'b1, ed_cnt, ed_pos);
        check("push+pop count", FW'(count), FW'(DEPTH));
        check("push+pop overflow kept", FW'(overflow), FW'(1));
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        check("ovf_clr", FW'(overflow), FW'(0));
        drain_en = 1'b1;
        wait_empty("final drain");
        check("final count", FW'(count), FW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
